mgt_01_fp_round_unit: RTL

Floating-point rounding stage directly downstream of the FP arithmetic units (fused mul-add, add, mul). It receives an unrounded single-precision result carrying guard/round/sticky bits plus the upstream exception flags. It applies the RISC-V rounding mode, resolves overflow and underflow, and delivers the IEEE-754 result and per-operation fflags through a 2-stage elastic valid/ready pipeline to the writeback logic.

---
 rtl/mgt_01_fp_round_unit_pkg.sv | 64 ++++++
 rtl/mgt_01_fp_round_unit_incr.sv | 29 ++
 rtl/mgt_01_fp_round_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mgt_01_fp_round_unit_pkg.sv
// rtl/mgt_01_fp_round_unit_pkg.sv - shared types and constants for the FP rounding stage
package mgt_01_fp_round_unit_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
        logic [2:0]  grs;
    } round_in_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic [2:0] {
        RM_RNE  = 3'b000,
        RM_RTZ  = 3'b001,
        RM_RDN  = 3'b010,
        RM_RUP  = 3'b011,
        RM_RMM  = 3'b100,
        RM_RSV5 = 3'b101,
        RM_RSV6 = 3'b110,
        RM_DYN  = 3'b111
    } rnd_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Everything S2 needs to finish the rounding; guard bits are already folded into inc/inexact.
    typedef struct packed {
        float_t    op;
        rnd_mode_e rm;
        logic      rsv;
        logic      inc;
        logic      inexact;
        logic      inv;
        logic      ovf;
        logic      udf;
    } s1_t;

    localparam logic [31:0] CANO_NAN   = 32'h7FC0_0000;
    localparam logic [31:0] P_INFTY    = 32'h7F80_0000;
    localparam logic [31:0] N_INFTY    = 32'hFF80_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    function automatic float_t overflow_result(input logic sign, input rnd_mode_e rm);
        logic [30:0] mag;
        case (rm)
            RM_RTZ:  mag = MAX_FINITE[30:0];
            RM_RDN:  mag = sign ? P_INFTY[30:0] : MAX_FINITE[30:0];
            RM_RUP:  mag = sign ? MAX_FINITE[30:0] : P_INFTY[30:0];
            default: mag = P_INFTY[30:0];
        endcase
        return float_t'({sign, mag});
    endfunction

endpackage

// File: rtl/mgt_01_fp_round_unit_incr.sv
// rtl/mgt_01_fp_round_unit_incr.sv - round-increment decision from sign, lsb, guard/round/sticky and rm
module mgt_01_fp_round_incr
    import mgt_01_fp_round_unit_pkg::*;
(
    input  logic      sign_i,
    input  logic      lsb_i,
    input  logic [2:0] grs_i,
    input  rnd_mode_e rm_i,
    output logic      inc_o,
    output logic      inexact_o
);

    logic inexact;

    always_comb begin
        inexact = |grs_i;
        inc_o   = 1'b0;
        case (rm_i)
            RM_RNE:  inc_o = grs_i[2] & (grs_i[1] | grs_i[0] | lsb_i);
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = sign_i & inexact;
            RM_RUP:  inc_o = ~sign_i & inexact;
            RM_RMM:  inc_o = grs_i[2];
            default: inc_o = 1'b0;
        endcase
        inexact_o = inexact;
    end

endmodule

// File: rtl/mgt_01_fp_round_unit.sv
// rtl/mgt_01_fp_round_unit.sv - 2-stage elastic FP32 rounding stage; FP_ROUND_FLAGS_ACC_EN adds a sticky flag accumulator
module mgt_01_fp_round_unit
    import mgt_01_fp_round_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  round_in_t  operand_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    input  logic       invalid_i,
    input  logic       overflow_i,
    input  logic       underflow_i,
`ifdef FP_ROUND_FLAGS_ACC_EN
    input  logic       clear_flags_i,
    output fflags_t    fflags_acc_o,
`endif
    output logic       valid_o,
    input  logic       ready_i,
    output float_t     result_o,
    output fflags_t    fflags_o
);

    logic      s1_valid_q, s1_valid_d;
    s1_t       s1_q, s1_d;
    logic      s2_valid_q, s2_valid_d;
    float_t    result_q, result_d;
    fflags_t   fflags_q, fflags_d;

    logic      s1_ready, s2_ready;
    rnd_mode_e rm_eff;
    logic      inc, inexact;
    logic [30:0] sum;
    float_t    rnd_result;
    fflags_t   rnd_flags;

    assign rm_eff = (rm_i == RM_DYN) ? rnd_mode_e'(frm_i) : rnd_mode_e'(rm_i);

    mgt_01_fp_round_incr u_incr (
        .sign_i    (operand_i.sign),
        .lsb_i     (operand_i.mantissa[0]),
        .grs_i     (operand_i.grs),
        .rm_i      (rm_eff),
        .inc_o     (inc),
        .inexact_o (inexact)
    );

    assign s2_ready = !s2_valid_q || ready_i;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign ready_o  = clk_en_i && s1_ready;

    // Carry out of the mantissa lands in the exponent, so subnormal->normal and max->inf fall out naturally.
    assign sum = {s1_q.op.exponent, s1_q.op.mantissa} + {30'd0, s1_q.inc};

    always_comb begin
        rnd_result = float_t'({s1_q.op.sign, sum});
        rnd_flags  = '0;
        if (s1_q.rsv || s1_q.inv) begin
            rnd_result   = float_t'(CANO_NAN);
            rnd_flags.nv = 1'b1;
        end else if (s1_q.op.exponent == 8'hFF) begin
            rnd_result = (s1_q.op.mantissa != '0) ? float_t'(CANO_NAN) : s1_q.op;
        end else if (s1_q.ovf || sum[30:23] == 8'hFF) begin
            rnd_result   = overflow_result(s1_q.op.sign, s1_q.rm);
            rnd_flags.of = 1'b1;
            rnd_flags.nx = 1'b1;
        end else if (s1_q.udf) begin
            rnd_result   = float_t'({s1_q.op.sign, 31'd0});
            rnd_flags.uf = 1'b1;
            rnd_flags.nx = 1'b1;
        end else begin
            rnd_flags.uf = (sum[30:23] == 8'h00) && s1_q.inexact;
            rnd_flags.nx = s1_q.inexact;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        fflags_d   = fflags_q;
        if (clk_en_i) begin
            if (s2_ready) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    result_d = rnd_result;
                    fflags_d = rnd_flags;
                end
            end
            if (s1_ready) begin
                s1_valid_d = valid_i;
                if (valid_i) begin
                    s1_d.op      = float_t'(operand_i[34:3]);
                    s1_d.rm      = rm_eff;
                    s1_d.rsv     = (rm_eff == RM_RSV5) || (rm_eff == RM_RSV6) || (rm_eff == RM_DYN);
                    s1_d.inc     = inc;
                    s1_d.inexact = inexact;
                    s1_d.inv     = invalid_i;
                    s1_d.ovf     = overflow_i;
                    s1_d.udf     = underflow_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            fflags_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            fflags_q   <= fflags_d;
        end
    end

    assign valid_o  = s2_valid_q;
    assign result_o = result_q;
    assign fflags_o = fflags_q;

`ifdef FP_ROUND_FLAGS_ACC_EN
    fflags_t acc_q, acc_d;
    logic    out_hs;

    assign out_hs = s2_valid_q && ready_i;

    // A clear coinciding with a handshake keeps that handshake's flags rather than dropping them.
    always_comb begin
        acc_d = acc_q;
        if (clk_en_i) begin
            if (clear_flags_i) begin
                acc_d = out_hs ? fflags_q : fflags_t'('0);
            end else if (out_hs) begin
                acc_d = fflags_t'(acc_q | fflags_q);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fflags_acc_o = acc_q;
`endif

endmodule
